// File: rtl/seg_pkg.sv
// Shared definitions for the K-means segmentation accelerator.
//   loader_state_t : pixel_stream_loader FSM states
//   PIXEL_WIDTH    : packed RGB pixel width
//   pixel_t        : {r, g, b} pixel, shared with the core and the output stage
package seg_pkg;

  localparam int unsigned PIXEL_WIDTH = 24;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } loader_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/pixel_stream_loader.sv
// AXI-Stream to input-image BRAM loader.
// Accepts a frame of RGB pixels on s_axis_*, writes pixel i to BRAM word i, checks
// tlast framing against the programmed frame length and pulses done when the frame
// has fully landed in BRAM.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, num_pixels        : frame start pulse and frame length (sampled in idle)
//   s_axis_tdata/tvalid/
//   s_axis_tready/tlast      : pixel stream, pixel in tdata[23:0]
//   img_addr/din/en/we       : BRAM write port, registered one cycle after handshake
//   busy, done               : status; done pulses once per frame
//   err_early_last           : sticky, tlast arrived before num_pixels pixels
//   err_late_last            : sticky, no tlast on pixel num_pixels-1
//   pixel_count              : pixels written in the current or most recent frame
module pixel_stream_loader #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned PIXEL_WIDTH = 24,
  parameter int unsigned TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            num_pixels,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [ADDR_WIDTH-1:0]  img_addr,
  output logic [PIXEL_WIDTH-1:0] img_din,
  output logic                   img_en,
  output logic                   img_we,
  output logic                   busy,
  output logic                   done,
  output logic                   err_early_last,
  output logic                   err_late_last,
  output logic [31:0]            pixel_count
);

  import seg_pkg::*;

  loader_state_t          state_q, state_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            npix_q, npix_d;
  logic                   early_q, early_d;
  logic                   late_q, late_d;
  logic                   tready_q, tready_d;
  logic                   we_q, we_d;
  logic                   done_q, done_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [PIXEL_WIDTH-1:0] din_q, din_d;

  logic handshake;
  logic at_last_pixel;

  // Upper tdata byte carries no pixel information.
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata[TDATA_WIDTH-1:PIXEL_WIDTH];

  assign handshake     = s_axis_tvalid & tready_q;
  // Only evaluated in run, where npix_q is known to be non-zero.
  assign at_last_pixel = (count_q == npix_q - 32'd1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    npix_d  = npix_q;
    early_d = early_q;
    late_d  = late_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    // done follows the done state by a cycle so it lands after the last BRAM write.
    done_d  = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // A zero-length frame is still a frame, so its count reads back as 0.
          count_d = '0;
          early_d = 1'b0;
          late_d  = 1'b0;
          npix_d  = num_pixels;
          state_d = (num_pixels == 32'd0) ? StDone : StRun;
        end
      end

      StRun: begin
        if (handshake) begin
          we_d    = 1'b1;
          addr_d  = ADDR_WIDTH'(count_q);
          din_d   = s_axis_tdata[PIXEL_WIDTH-1:0];
          count_d = count_q + 32'd1;
          if (s_axis_tlast) begin
            early_d = early_q | ~at_last_pixel;
            state_d = StDone;
          end else if (at_last_pixel) begin
            late_d  = 1'b1;
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (handshake && s_axis_tlast) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered ready tracks the state being entered, so it drops right after the
    // terminating beat and no beat is ever taken in idle or done.
    tready_d = (state_d == StRun) || (state_d == StDrain);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      npix_q   <= '0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      tready_q <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      npix_q   <= npix_d;
      early_q  <= early_d;
      late_q   <= late_d;
      tready_q <= tready_d;
      we_q     <= we_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign img_addr       = addr_q;
  assign img_din        = din_q;
  assign img_en         = we_q;
  assign img_we         = we_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign err_early_last = early_q;
  assign err_late_last  = late_q;
  assign pixel_count    = count_q;

endmodule

// File: doc/pixel_stream_loader.md
# pixel_stream_loader

Front-end stage of the K-means segmentation accelerator. Accepts the input image as an AXI-Stream of 24-bit RGB pixels and writes each pixel into the input-image BRAM that the segmentation core later reads on its image port. It counts pixels against a programmed frame length, checks framing against `tlast`, and reports completion and framing errors to the control logic behind the AXI-Lite register bank.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: BRAM write address width; matches the core's image address width.
- `PIXEL_WIDTH`, 24: RGB pixel width, packed `{R[23:16], G[15:8], B[7:0]}`.
- `TDATA_WIDTH`, 32: stream width. The pixel occupies bits `[23:0]`; bits `[31:24]` are ignored.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: one-cycle pulse that starts a frame. Honoured only in IDLE.
- `num_pixels`, in, 32: frame length. Sampled on an accepted `start`.
- `s_axis_tdata`, in, `TDATA_WIDTH`: pixel data.
- `s_axis_tvalid`, in, 1: source has a valid beat.
- `s_axis_tready`, out, 1: loader can accept a beat.
- `s_axis_tlast`, in, 1: final beat of the frame.
- `img_addr`, out, `ADDR_WIDTH`: BRAM word address.
- `img_din`, out, `PIXEL_WIDTH`: BRAM write data.
- `img_en`, out, 1: BRAM enable.
- `img_we`, out, 1: BRAM write enable.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `err_early_last`, out, 1: sticky error flag.
- `err_late_last`, out, 1: sticky error flag.
- `pixel_count`, out, 32: number of pixels written in the current or most recent frame.

## Operation
States:
- **IDLE**
  - `start` with `num_pixels`=0 → DONE. No writes occur.
  - `start` with `num_pixels`>0 → RUN. On entry, `pixel_count` and both error flags clear, and `num_pixels` is latched.
- **RUN**
  - `s_axis_tready`=1.
  - Each handshake (`tvalid & tready`) writes the pixel to address `pixel_count`, then increments `pixel_count`.
  - Beat with `tlast`=1 and count = N-1 → DONE. This is the normal end of frame.
  - Beat with `tlast`=1 and count < N-1 → pixel is written, `err_early_last` is set, → DONE.
  - Beat with `tlast`=0 and count = N-1 → pixel is written, `err_late_last` is set, → DRAIN.
- **DRAIN**
  - `s_axis_tready`=1.
  - Beats are discarded: no BRAM write and no count change.
  - Beat with `tlast`=1 → DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then → IDLE.

General rules:
- `start` is ignored when `busy`=1. The latched `num_pixels` is unaffected.
- Error flags and `pixel_count` hold their values in IDLE until the next accepted `start`.
- Address arithmetic: `img_addr` is the zero-extended `pixel_count` (word addressing, +1 per pixel). It never wraps within a frame, since `num_pixels` is at most 2^32-1.
- `tdata[31:24]` is discarded.

## Timing
- Reset values:
  - State is IDLE.
  - `s_axis_tready`, `img_en`, `img_we`, `done`, `busy`, and both error flags are 0.
  - `img_addr`, `img_din`, and `pixel_count` are 0.
- Write latency: the BRAM write is registered and occurs one cycle after the handshake. `img_en`=`img_we`=1 for exactly that cycle, with `img_addr`/`img_din` valid in the same cycle. Outside write cycles `img_en`=`img_we`=0.
- Throughput is one pixel per cycle with no bubbles while `tvalid` stays high.
- `s_axis_tready` is registered. It rises the cycle after the IDLE→RUN transition and falls the cycle after the terminating beat. No beat is accepted in IDLE or DONE.
- `done` asserts the cycle after the final BRAM write, so all frame data is in BRAM when `done` is seen.
- `tvalid` deasserted mid-frame: the loader stalls with no write and no timeout.
- `rst` mid-frame: everything returns to reset values on the next edge. A pending registered write is dropped and no `done` is issued.
- `start` coincident with `rst`: `rst` wins.

## Structure
- Shared package `seg_pkg` holds:
  - `loader_state_t` (IDLE, RUN, DRAIN, DONE).
  - `PIXEL_WIDTH`=24.
  - A `pixel_t` struct `{r, g, b}` shared with the segmentation core and the output stage.
- Single module; no sub-module is needed. The counter and the FSM are kept inline.

## Test plan
- **Normal frame.** `num_pixels`=4; beats 0x00112233, 0x00445566, 0x00778899, 0x00AABBCC, with `tlast` on the 4th.
  - Writes at addresses 0..3 with matching 24-bit data.
  - `done` pulses once, the cycle after the write to address 3.
  - `pixel_count`=4; both error flags 0.
- **Early last.** `num_pixels`=8; `tlast` on beat 3.
  - 3 writes occur.
  - `err_early_last`=1, `done` pulses, `pixel_count`=3.
- **Late last.** `num_pixels`=2; 5 beats with `tlast` on beat 5.
  - Only addresses 0 and 1 are written.
  - Beats 3–5 are consumed with `tready`=1.
  - `err_late_last`=1, `done` pulses after beat 5.
- **Zero length and ignored start.**
  - `num_pixels`=0: `done` pulses 2 cycles after `start`, with no `img_we` and `tready` never high.
  - A second `start` issued mid-frame has no effect.
- **Backpressure and upper-byte masking.** Random `tvalid` gaps in a 16-pixel frame, with `tdata[31:24]`=0xFF on every beat.
  - All 16 written in order.
  - `img_din` upper byte absent.
  - No write in gap cycles.
- **Reset mid-frame.** `rst` asserted after 5 of 10 pixels.
  - Next cycle: all outputs at reset values, no `done`, no further writes.
  - A new frame afterwards starts at address 0.
